// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the ALU sequencer: default widths, FSM state codes
// and bit offsets of the fields inside a program entry.
// Program entry layout (MSB..LSB): {opcode[M], rd[2], rs1[2], rs2[2]}.
package alu_sequencer_pkg;

  localparam int N_DEF = 4;   // operand/result width
  localparam int M_DEF = 4;   // ALU instruction width
  localparam int D_DEF = 16;  // program memory depth

  // Field offsets within a program entry; the opcode occupies the top M bits.
  localparam int RS2_LSB = 0;
  localparam int RS1_LSB = 2;
  localparam int RD_LSB  = 4;
  localparam int OP_LSB  = 6;

  // FSM state encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WB    = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/alu_regfile.sv
// Purpose: 4 x N register file, one synchronous write port, three combinational reads.
// Latency: reads are combinational; a write is visible the cycle after it is issued.
// Backpressure: none; the write port is always accepted.
// Ports: clk/rst_n clock and async active-low reset (clears all registers);
//        we_i/waddr_i/wdata_i write port; raddrN_i/rdataN_o read ports 0..2.
module alu_regfile
  import alu_sequencer_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we_i,
  input  logic [1:0]   waddr_i,
  input  logic [N-1:0] wdata_i,
  input  logic [1:0]   raddr0_i,
  input  logic [1:0]   raddr1_i,
  input  logic [1:0]   raddr2_i,
  output logic [N-1:0] rdata0_o,
  output logic [N-1:0] rdata1_o,
  output logic [N-1:0] rdata2_o
);

  logic [N-1:0] regs_q [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata0_o = regs_q[raddr0_i];
  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/alu_sequencer.sv
// Purpose: steps a stored program through an external combinational ALU, writing results to a regfile.
// Latency: 3 cycles per instruction (FETCH, ISSUE, WB); done pulses 3*prog_len+1 cycles after start.
// Backpressure: none; prog_we, reg_we and start are dropped unless the sequencer is IDLE.
// Ports: clk/rst_n; prog_we/prog_addr/prog_data program load; reg_we/reg_addr/reg_wdata preload,
//        reg_rdata readback; start/prog_len launch; busy/done status; alu_a/alu_b/alu_instr to the
//        external ALU, alu_result back from it.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter  int N  = N_DEF,
  parameter  int M  = M_DEF,
  parameter  int D  = D_DEF,
  localparam int PW = $clog2(D)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [PW-1:0] prog_addr,
  input  logic [M+5:0]  prog_data,
  input  logic          reg_we,
  input  logic [1:0]    reg_addr,
  input  logic [N-1:0]  reg_wdata,
  output logic [N-1:0]  reg_rdata,
  input  logic          start,
  input  logic [PW:0]   prog_len,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [M-1:0]  alu_instr,
  input  logic [N-1:0]  alu_result
);

  logic [2:0]   state_q, state_d;
  // pc/len carry one extra bit so a full-depth program (len == D) is representable.
  logic [PW:0]  pc_q, pc_d;
  logic [PW:0]  len_q, len_d;
  logic [PW:0]  pc_inc;
  logic [PW:0]  len_clamped;
  logic [M+5:0] ir_q, ir_d;
  logic [N-1:0] alu_a_q, alu_a_d;
  logic [N-1:0] alu_b_q, alu_b_d;
  logic [M-1:0] alu_instr_q, alu_instr_d;

  logic [M+5:0] mem_q [D];

  logic         idle;
  logic         rf_we;
  logic [1:0]   rf_waddr;
  logic [N-1:0] rf_wdata;
  logic [N-1:0] rs1_dat, rs2_dat;

  assign idle        = (state_q == ST_IDLE);
  assign pc_inc      = pc_q + (PW+1)'(1);
  assign len_clamped = (prog_len > (PW+1)'(D)) ? (PW+1)'(D) : prog_len;

  // Program memory is deliberately left out of reset so a program survives an abort.
  always_ff @(posedge clk) begin
    if (prog_we && idle) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // The regfile write port is shared: host preload while idle, ALU writeback in WB.
  assign rf_we    = (state_q == ST_WB) || (idle && reg_we);
  assign rf_waddr = (state_q == ST_WB) ? ir_q[RD_LSB +: 2] : reg_addr;
  assign rf_wdata = (state_q == ST_WB) ? alu_result : reg_wdata;

  alu_regfile #(.N(N)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .raddr0_i (ir_q[RS1_LSB +: 2]),
    .raddr1_i (ir_q[RS2_LSB +: 2]),
    .raddr2_i (reg_addr),
    .rdata0_o (rs1_dat),
    .rdata1_o (rs2_dat),
    .rdata2_o (reg_rdata)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    len_d       = len_q;
    ir_d        = ir_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_instr_d = alu_instr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (prog_len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
            pc_d    = '0;
            len_d   = len_clamped;
          end
        end
      end
      ST_FETCH: begin
        ir_d    = mem_q[pc_q[PW-1:0]];
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // Operands are read here, one cycle before WB, so rs == rd sees the old value.
        alu_a_d     = rs1_dat;
        alu_b_d     = rs2_dat;
        alu_instr_d = ir_q[OP_LSB +: M];
        state_d     = ST_WB;
      end
      ST_WB: begin
        pc_d    = pc_inc;
        state_d = (pc_inc < len_q) ? ST_FETCH : ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      len_q       <= '0;
      ir_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      len_q       <= len_d;
      ir_q        <= ir_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_instr_q <= alu_instr_d;
    end
  end

  assign busy      = !idle;
  assign done      = (state_q == ST_DONE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_instr = alu_instr_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with default parameters (N=4, M=4, D=16).
// The external ALU is modelled here: opcode MSB set -> A & B, clear -> A + B mod 16.
// Single-instruction cases run from a vector table; multi-cycle corners are hand-written.
module tb_alu_sequencer;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [9:0] prog_data;
  logic       reg_we;
  logic [1:0] reg_addr;
  logic [3:0] reg_wdata;
  logic [3:0] reg_rdata;
  logic       start;
  logic [4:0] prog_len;
  logic       busy;
  logic       done;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_instr;
  logic [3:0] alu_result;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign alu_result = alu_instr[3] ? (alu_a & alu_b) : (alu_a + alu_b);

  alu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .reg_we     (reg_we),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .start      (start),
    .prog_len   (prog_len),
    .busy       (busy),
    .done       (done),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_instr  (alu_instr),
    .alu_result (alu_result)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [1:0] rd;
    logic [3:0] exp;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [9:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction

  task automatic preload(input logic [1:0] a, input logic [3:0] v);
    reg_we = 1'b1; reg_addr = a; reg_wdata = v;
    @(posedge clk); #1;
    reg_we = 1'b0;
  endtask

  task automatic load_prog(input logic [3:0] a, input logic [9:0] w);
    prog_we = 1'b1; prog_addr = a; prog_data = w;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output int v);
    reg_addr = a;
    #1;
    v = int'(reg_rdata);
  endtask

  // Cycle 1 is the first cycle after the edge that samples start; cyc reports the cycle
  // in which done is high, or -1 if it never rose within limit cycles.
  task automatic run_prog(input logic [4:0] len, input int limit, input bit poke, output int cyc);
    bit seen = 1'b0;
    start = 1'b1; prog_len = len;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!seen && cyc <= limit) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!seen) cyc = -1;
    else begin
      if (poke) begin start = 1'b1; prog_len = 5'd1; end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  initial begin
    int v, cyc;
    bit saw_done;

    vt[0] = '{a: 4'd3,  b: 4'd5,  op: OP_ADD, rd: 2'd0, exp: 4'd8};
    vt[1] = '{a: 4'd12, b: 4'd10, op: OP_AND, rd: 2'd3, exp: 4'd8};
    vt[2] = '{a: 4'd15, b: 4'd1,  op: OP_ADD, rd: 2'd0, exp: 4'd0};
    vt[3] = '{a: 4'd9,  b: 4'd9,  op: OP_ADD, rd: 2'd3, exp: 4'd2};
    vt[4] = '{a: 4'd15, b: 4'd6,  op: OP_AND, rd: 2'd0, exp: 4'd6};
    vt[5] = '{a: 4'd0,  b: 4'd7,  op: OP_AND, rd: 2'd3, exp: 4'd0};
    vt[6] = '{a: 4'd6,  b: 4'd9,  op: OP_ADD, rd: 2'd1, exp: 4'd15};
    vt[7] = '{a: 4'd10, b: 4'd5,  op: OP_AND, rd: 2'd2, exp: 4'd0};

    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    reg_we = 1'b0; reg_addr = '0; reg_wdata = '0; start = 1'b0; prog_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_alu_a", int'(alu_a), 0);
    chk("reset_alu_instr", int'(alu_instr), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) begin
      rd_reg(r[1:0], v);
      chk($sformatf("reset_r%0d", r), v, 0);
    end

    // Single-instruction table: rs1 = r1, rs2 = r2, rd from the table.
    for (int i = 0; i < 8; i++) begin
      preload(2'd1, vt[i].a);
      preload(2'd2, vt[i].b);
      load_prog(4'd0, enc(vt[i].op, vt[i].rd, 2'd1, 2'd2));
      run_prog(5'd1, 20, 1'b0, cyc);
      chk($sformatf("vec%0d_latency", i), cyc, 4);
      rd_reg(vt[i].rd, v);
      chk($sformatf("vec%0d_result", i), v, int'(vt[i].exp));
    end
    chk("done_one_cycle", int'(done), 0);

    // AND r3,r1,r2: opcode visible to the ALU during WB (cycle 3); operands hold afterwards.
    preload(2'd1, 4'd12);
    preload(2'd2, 4'd10);
    preload(2'd3, 4'd0);
    load_prog(4'd0, enc(OP_AND, 2'd3, 2'd1, 2'd2));
    start = 1'b1; prog_len = 5'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("wb_alu_instr", int'(alu_instr), 8);
    chk("wb_alu_a", int'(alu_a), 12);
    chk("wb_alu_b", int'(alu_b), 10);
    saw_done = 1'b0;
    for (int k = 0; k < 10 && !saw_done; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("and_done_seen", int'(saw_done), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("alu_a_hold_idle", int'(alu_a), 12);
    rd_reg(2'd3, v);
    chk("and_r3", v, 8);

    // Two instructions with rs == rd and a wrap; a start pulse on the DONE cycle is ignored.
    preload(2'd0, 4'd9);
    preload(2'd1, 4'd15);
    preload(2'd2, 4'd1);
    load_prog(4'd0, enc(OP_ADD, 2'd1, 2'd1, 2'd2));
    load_prog(4'd1, enc(OP_ADD, 2'd0, 2'd1, 2'd1));
    run_prog(5'd2, 20, 1'b1, cyc);
    chk("two_instr_latency", cyc, 7);
    chk("start_on_done_ignored", int'(busy), 0);
    rd_reg(2'd1, v);
    chk("two_instr_r1", v, 0);
    rd_reg(2'd0, v);
    chk("two_instr_r0", v, 0);

    // Zero-length program: done in cycle 1, registers untouched.
    preload(2'd0, 4'd4);
    preload(2'd3, 4'd7);
    run_prog(5'd0, 10, 1'b0, cyc);
    chk("len0_latency", cyc, 1);
    rd_reg(2'd0, v);
    chk("len0_r0", v, 4);
    rd_reg(2'd3, v);
    chk("len0_r3", v, 7);

    // Reset asserted during the second WB (cycle 6) of a three-instruction program.
    preload(2'd1, 4'd1);
    preload(2'd2, 4'd2);
    load_prog(4'd0, enc(OP_ADD, 2'd0, 2'd1, 2'd2));
    load_prog(4'd1, enc(OP_ADD, 2'd3, 2'd1, 2'd2));
    load_prog(4'd2, enc(OP_ADD, 2'd2, 2'd1, 2'd1));
    start = 1'b1; prog_len = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_busy_before", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_alu_a", int'(alu_a), 0);
    rd_reg(2'd0, v);
    chk("abort_r0", v, 0);
    rd_reg(2'd3, v);
    chk("abort_r3", v, 0);
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort_no_done", int'(saw_done), 0);
    @(posedge clk); #1;
    // Program memory survives reset: entry 0 is still ADD r0,r1,r2.
    preload(2'd1, 4'd1);
    preload(2'd2, 4'd2);
    run_prog(5'd1, 20, 1'b0, cyc);
    rd_reg(2'd0, v);
    chk("mem_kept_r0", v, 3);

    // Full-depth program with writes and a start attempted while busy.
    for (int a = 0; a < 15; a++) load_prog(a[3:0], enc(OP_ADD, 2'd1, 2'd1, 2'd2));
    load_prog(4'd15, enc(OP_AND, 2'd3, 2'd1, 2'd2));
    preload(2'd1, 4'd0);
    preload(2'd2, 4'd1);
    preload(2'd3, 4'd0);
    fork
      run_prog(5'd16, 60, 1'b0, cyc);
      begin
        repeat (3) @(posedge clk);
        #2;
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = enc(OP_AND, 2'd1, 2'd1, 2'd2);
        reg_we = 1'b1; reg_addr = 2'd2; reg_wdata = 4'd9;
        start = 1'b1; prog_len = 5'd1;
        @(posedge clk); #1;
        prog_we = 1'b0; reg_we = 1'b0; start = 1'b0;
      end
    join
    chk("full_latency", cyc, 49);
    rd_reg(2'd1, v);
    chk("full_r1", v, 15);
    rd_reg(2'd3, v);
    chk("full_r3", v, 1);
    rd_reg(2'd2, v);
    chk("busy_reg_we_ignored", v, 1);

    // Over-length request clamps to the full depth.
    preload(2'd1, 4'd0);
    run_prog(5'd31, 80, 1'b0, cyc);
    chk("clamp_latency", cyc, 49);
    rd_reg(2'd1, v);
    chk("clamp_r1", v, 15);

    // Entry 0 was not overwritten by the busy-time prog_we: still ADD r1,r1,r2.
    preload(2'd1, 4'd2);
    preload(2'd2, 4'd3);
    run_prog(5'd1, 20, 1'b0, cyc);
    rd_reg(2'd1, v);
    chk("busy_prog_we_ignored", v, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter N, default 4, operand/result width in bits.
REQ-002 Parameter M, default 4, ALU instruction width; MSB selects logical (1) or arithmetic (0) unit.
REQ-003 Parameter D, default 16, program memory depth in entries; PW = clog2(D).
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 prog_we  input  1  write program entry; honoured only in IDLE.
REQ-007 prog_addr  input  PW  program write address.
REQ-008 prog_data  input  M+6  entry {opcode[M], rd[2], rs1[2], rs2[2]}, opcode in the MSBs.
REQ-009 reg_we  input  1  preload register; honoured only in IDLE.
REQ-010 reg_addr  input  2  preload/readback register index.
REQ-011 reg_wdata  input  N  preload data.
REQ-012 reg_rdata  output  N  combinational readback of regfile[reg_addr].
REQ-013 start  input  1  begin execution; sampled only in IDLE.
REQ-014 prog_len  input  PW+1  instruction count, sampled with start; valid range 0..D.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on completion.
REQ-017 alu_a, alu_b  output  N  registered operands to the external ALU.
REQ-018 alu_instr  output  M  registered opcode to the external ALU.
REQ-019 alu_result  input  N  combinational result from the external ALU.

Function
REQ-020 The block SHALL hold a 4 x N register file and a D x (M+6) program memory, both synchronous-write.
REQ-021 States SHALL be IDLE, FETCH, ISSUE, WB, DONE.
REQ-022 IDLE->FETCH on start with prog_len != 0: pc<=0, len<=prog_len; IDLE->DONE on start with prog_len == 0.
REQ-023 FETCH SHALL latch mem[pc] into an instruction register; next state ISSUE.
REQ-024 ISSUE SHALL load alu_a<=reg[rs1], alu_b<=reg[rs2], alu_instr<=opcode; next state WB.
REQ-025 WB SHALL write alu_result into reg[rd] and increment pc; next state FETCH if pc+1 < len, else DONE.
REQ-026 Each instruction SHALL take exactly 3 cycles; total start-to-done latency SHALL be 3*prog_len+1 cycles.
REQ-027 DONE SHALL assert done for one cycle and return to IDLE.
REQ-028 rs1/rs2 equal to rd SHALL read the pre-write value (write occurs in WB, after ISSUE).
REQ-029 prog_we, reg_we and start SHALL be ignored while busy; a start pulse on the DONE cycle SHALL be ignored.
REQ-030 prog_len > D SHALL be clamped to D.
REQ-031 alu_a, alu_b and alu_instr SHALL hold their last values outside ISSUE.
REQ-032 pc SHALL be PW+1 bits wide so that pc == D is representable without wrap.

Reset
REQ-033 rst_n low SHALL force IDLE, pc=0, len=0, done=0, busy=0, alu_a=0, alu_b=0, alu_instr=0, all registers 0, immediately and regardless of clk.
REQ-034 Program memory contents SHALL NOT be reset.
REQ-035 Reset mid-execution SHALL abort without a partial writeback and without a done pulse.

Structure
REQ-036 A shared package SHALL hold the state enumeration, field offsets of the program entry, and the default N, M, D constants.
REQ-037 The register file SHALL be one sub-module, alu_regfile (4 x N, 1 write port, 3 combinational read ports).

Verification (bench models the ALU: opcode 0000 = A+B mod 2^N, 1000 = A&B)
REQ-038 Preload r1=3, r2=5; program [ADD r0,r1,r2]; start, len=1 -> done after 4 cycles, r0=8.
REQ-039 Preload r1=12, r2=10; [AND r3,r1,r2] -> r3=8; alu_instr observed as 1000 during WB.
REQ-040 r1=15, r2=1; [ADD r1,r1,r2; ADD r0,r1,r1] -> r1=0 (wrap), r0=0, done at cycle 7.
REQ-041 start with len=0 -> done pulses next cycle, registers unchanged.
REQ-042 rst_n low during the second WB of a 3-instruction program -> IDLE, registers 0, no done.
REQ-043 prog_we/reg_we/start while busy -> no effect; a 16-instruction program completes with done at cycle 49.
